// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_arbiter
// Description : Shares a single-port 256x8 RAM between the SPI slave command
//               stream and a local host port.
//               10-bit SPI words are decoded as follows:
//                 00 load write address
//                 01 write payload
//                 10 load read address
//                 11 read
//               SPI read data is returned on tx_data/tx_valid. The host is
//               served in the gaps between SPI accesses. A starvation counter
//               forces one host slot after STARVE_LIMIT back-to-back SPI
//               grants.
// Ports       : clk, rstn (sync, active-low)
//               rx_data/rx_valid        SPI word in (captured on the rising
//                                       edge of rx_valid)
//               tx_data/tx_valid        SPI read data out (level)
//               host_req/we/addr/wdata  host request
//               host_gnt                host request issued (pulse)
//               host_rvalid/host_rdata  host read return (pulse)
//               ram_en/we/addr/wdata    RAM command
//               ram_rdata               RAM read data (one cycle latency)
//               err_overrun             sticky: an SPI RAM command was lost
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_arbiter #(
    parameter int STARVE_LIMIT = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_gnt,
    output logic       host_rvalid,
    output logic [7:0] host_rdata,
    output logic       ram_en,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       err_overrun
);

    localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] c_CMD_WADDR = 2'b00;
    localparam logic [1:0] c_CMD_RADDR = 2'b10;

    typedef enum logic [1:0] {
        c_ST_IDLE    = 2'd0,
        c_ST_ACC     = 2'd1,
        c_ST_RD_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic               r_rx_valid_d;
    logic [7:0]         r_wr_addr;
    logic [7:0]         r_rd_addr;
    logic               r_spi_pend;
    logic               r_pend_we;
    logic [7:0]         r_pend_addr;
    logic [7:0]         r_pend_wdata;
    logic               r_owner_host;
    logic [c_CNT_W-1:0] r_starve_cnt;

    logic       r_ram_en;
    logic       r_ram_we;
    logic [7:0] r_ram_addr;
    logic [7:0] r_ram_wdata;
    logic       r_host_gnt;
    logic       r_host_rvalid;
    logic [7:0] r_host_rdata;
    logic [7:0] r_tx_data;
    logic       r_tx_valid;
    logic       r_err_overrun;

    logic       w_capture;
    logic [1:0] w_cmd;
    logic [7:0] w_payload;
    logic       w_cap_acc;
    logic       w_new_we;
    logic [7:0] w_new_addr;
    logic       w_eff_pend;
    logic       w_eff_we;
    logic [7:0] w_eff_addr;
    logic [7:0] w_eff_wdata;
    logic       w_starved;
    logic       w_spi_win;
    logic       w_spi_done;
    logic       w_grant_spi;
    logic       w_grant_host;

    // ------------------------------------------------------------------
    // SPI word decode. Only the rising edge of rx_valid captures a word.
    // ------------------------------------------------------------------
    assign w_capture  = rx_valid & ~r_rx_valid_d;
    assign w_cmd      = rx_data[9:8];
    assign w_payload  = rx_data[7:0];
    // Commands 01 and 11 are the ones that need a RAM slot.
    assign w_cap_acc  = w_capture & w_cmd[0];
    assign w_new_we   = ~w_cmd[1];
    assign w_new_addr = w_cmd[1] ? r_rd_addr : r_wr_addr;

    // A word captured this cycle is visible to the arbiter at once. This
    // lets an uncontended SPI access enter ACC on the capture edge itself.
    assign w_eff_pend  = r_spi_pend | w_cap_acc;
    assign w_eff_we    = w_cap_acc ? w_new_we   : r_pend_we;
    assign w_eff_addr  = w_cap_acc ? w_new_addr : r_pend_addr;
    assign w_eff_wdata = w_cap_acc ? w_payload  : r_pend_wdata;

    // The host wins against SPI in two cases:
    //   - it has waited through STARVE_LIMIT SPI grants;
    //   - the SPI word is only arriving this cycle (nothing registered yet).
    assign w_starved = (r_starve_cnt == c_LIMIT);
    assign w_spi_win = w_eff_pend & ~(host_req & (~r_spi_pend | w_starved));

    // The registered pend is consumed when its ACC cycle ends.
    assign w_spi_done = (r_state == c_ST_ACC) & ~r_owner_host;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_spi  = 1'b0;
        w_grant_host = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_spi_win) begin
                    w_grant_spi = 1'b1;
                    w_state_nxt = c_ST_ACC;
                end else if (host_req) begin
                    w_grant_host = 1'b1;
                    w_state_nxt  = c_ST_ACC;
                end
            end
            // r_ram_we holds the direction of the access in flight.
            c_ST_ACC:     w_state_nxt = r_ram_we ? c_ST_IDLE : c_ST_RD_WAIT;
            c_ST_RD_WAIT: w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rx_valid_d  <= 1'b0;
            r_wr_addr     <= 8'h00;
            r_rd_addr     <= 8'h00;
            r_spi_pend    <= 1'b0;
            r_pend_we     <= 1'b0;
            r_pend_addr   <= 8'h00;
            r_pend_wdata  <= 8'h00;
            r_owner_host  <= 1'b0;
            r_starve_cnt  <= '0;
            r_ram_en      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= 8'h00;
            r_ram_wdata   <= 8'h00;
            r_host_gnt    <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= 8'h00;
            r_tx_data     <= 8'h00;
            r_tx_valid    <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_rx_valid_d  <= rx_valid;

            // Strobes are high only in the cycle after the grant (ACC).
            // Address and write data keep their last values.
            r_ram_en      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_host_gnt    <= 1'b0;
            r_host_rvalid <= 1'b0;

            if (w_grant_spi) begin
                r_ram_en     <= 1'b1;
                r_ram_we     <= w_eff_we;
                r_ram_addr   <= w_eff_addr;
                r_ram_wdata  <= w_eff_wdata;
                r_owner_host <= 1'b0;
            end else if (w_grant_host) begin
                r_ram_en     <= 1'b1;
                r_ram_we     <= host_we;
                r_ram_addr   <= host_addr;
                r_ram_wdata  <= host_wdata;
                r_owner_host <= 1'b1;
                r_host_gnt   <= 1'b1;
            end

            if (!host_req || w_grant_host) begin
                r_starve_cnt <= '0;
            end else if (w_grant_spi && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
            end

            if (w_capture) begin
                r_tx_valid <= 1'b0;
                case (w_cmd)
                    c_CMD_WADDR: r_wr_addr <= w_payload;
                    c_CMD_RADDR: r_rd_addr <= w_payload;
                    default: begin
                        r_pend_we    <= w_new_we;
                        r_pend_addr  <= w_new_addr;
                        r_pend_wdata <= w_payload;
                        r_spi_pend   <= 1'b1;
                        // Replacing a pend that is being issued right now
                        // is the normal back-to-back case and loses nothing.
                        if (r_spi_pend && !w_spi_done) begin
                            r_err_overrun <= 1'b1;
                        end
                    end
                endcase
            end else if (w_spi_done) begin
                r_spi_pend <= 1'b0;
            end

            // A read return in the same cycle as a new capture still wins:
            // the data belongs to the most recent completed read.
            if (r_state == c_ST_RD_WAIT) begin
                if (r_owner_host) begin
                    r_host_rdata  <= ram_rdata;
                    r_host_rvalid <= 1'b1;
                end else begin
                    r_tx_data  <= ram_rdata;
                    r_tx_valid <= 1'b1;
                end
            end
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign host_gnt    = r_host_gnt;
    assign host_rvalid = r_host_rvalid;
    assign host_rdata  = r_host_rdata;
    assign ram_en      = r_ram_en;
    assign ram_we      = r_ram_we;
    assign ram_addr    = r_ram_addr;
    assign ram_wdata   = r_ram_wdata;
    assign err_overrun = r_err_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_ram_arbiter
// Description : Directed self-checking bench for spi_ram_arbiter with a
//               behavioural 256x8 RAM attached to the RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic       host_rvalid;
    logic [7:0] host_rdata;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       err_overrun;

    int n_checks = 0;
    int n_err    = 0;
    int wr_count = 0;
    int wr_base;

    logic [7:0] mem [0:255];

    always #5 clk = ~clk;

    spi_ram_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .err_overrun (err_overrun)
    );

    // Single-port RAM: read data appears the cycle after the access edge.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wr_count      <= wr_count + 1;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_rise(input logic [9:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        tick();
    endtask

    task automatic spi_fall();
        rx_valid = 1'b0;
        tick();
    endtask

    function automatic logic [63:0] all_outs();
        return {26'd0, tx_data, tx_valid, host_gnt, host_rvalid, host_rdata,
                ram_en, ram_we, ram_addr, ram_wdata, err_overrun};
    endfunction

    initial begin
        rstn       = 1'b0;
        rx_data    = 10'h000;
        rx_valid   = 1'b0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = 8'h00;
        host_wdata = 8'h00;
        repeat (3) tick();
        check("reset_outputs", all_outs(), 64'd0);
        rstn = 1'b1;
        repeat (2) tick();

        // ---------------- SPI write then read ----------------
        spi_rise(10'h0A5);
        check("addr_load_no_access", {ram_en, ram_we}, 2'b00);
        spi_fall();
        spi_rise(10'h13C);
        check("spi_write_acc", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, 8'hA5, 8'h3C});
        spi_fall();
        check("ram_hold_after_acc", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b0, 1'b0, 8'hA5, 8'h3C});
        spi_rise(10'h2A5);
        spi_fall();
        spi_rise(10'h300);
        check("spi_read_acc", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 8'hA5});
        spi_fall();
        check("tx_not_yet_k1", tx_valid, 1'b0);
        tick();
        check("tx_read_k2", {tx_valid, tx_data}, {1'b1, 8'h3C});
        repeat (4) tick();
        check("tx_held", {tx_valid, tx_data}, {1'b1, 8'h3C});

        // ---------------- rx_valid held high ----------------
        wr_base  = wr_count;
        rx_data  = 10'h177;
        rx_valid = 1'b1;
        tick();
        check("capture_clears_tx", tx_valid, 1'b0);
        repeat (4) tick();
        rx_valid = 1'b0;
        repeat (3) tick();
        check("held_level_one_write", wr_count - wr_base, 1);
        check("held_level_data", mem[8'hA5], 8'h77);
        spi_rise(10'h155);
        spi_fall();
        tick();
        check("retrigger_write", wr_count - wr_base, 2);
        check("retrigger_data", mem[8'hA5], 8'h55);

        // ---------------- host only ----------------
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 8'h10;
        host_wdata = 8'h55;
        tick();
        check("host_wr_gnt", {host_gnt, ram_en, ram_we, ram_addr, ram_wdata},
              {1'b1, 1'b1, 1'b1, 8'h10, 8'h55});
        host_req = 1'b0;
        tick();
        check("host_gnt_pulse", host_gnt, 1'b0);
        host_req = 1'b1;
        host_we  = 1'b0;
        tick();
        check("host_rd_gnt", {host_gnt, ram_en, ram_we, ram_addr}, {1'b1, 1'b1, 1'b0, 8'h10});
        host_req = 1'b0;
        tick();
        check("host_rvalid_early", host_rvalid, 1'b0);
        tick();
        check("host_rdata", {host_rvalid, host_rdata}, {1'b1, 8'h55});
        tick();
        check("host_rvalid_pulse", {host_rvalid, tx_valid}, 2'b00);

        // ---------------- contention / starvation bound ----------------
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 8'h80;
        host_wdata = 8'hEE;
        rx_data    = 10'h101;
        rx_valid   = 1'b1;
        tick();                                   // capture with host_req: host first
        check("cont_host_first", {host_gnt, ram_we, ram_addr}, {1'b1, 1'b1, 8'h80});
        rx_valid = 1'b0;
        tick();
        check("cont_idle_gap", ram_en, 1'b0);
        tick();                                   // SPI grant 1
        check("cont_spi_a", {host_gnt, ram_en, ram_we, ram_addr, ram_wdata},
              {1'b0, 1'b1, 1'b1, 8'hA5, 8'h01});
        rx_data  = 10'h102;
        rx_valid = 1'b1;
        tick();                                   // capture during ACC
        check("cont_no_overrun_b", {err_overrun, ram_en}, 2'b00);
        rx_valid = 1'b0;
        tick();                                   // SPI grant 2
        check("cont_spi_b", {host_gnt, ram_en, ram_wdata}, {1'b0, 1'b1, 8'h02});
        rx_data  = 10'h103;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();                                   // starved host forced in
        check("cont_host_forced", {host_gnt, ram_en, ram_we, ram_addr, ram_wdata},
              {1'b1, 1'b1, 1'b1, 8'h80, 8'hEE});
        host_req = 1'b0;
        tick();
        tick();
        check("cont_spi_c", {host_gnt, ram_en, ram_we, ram_addr, ram_wdata},
              {1'b0, 1'b1, 1'b1, 8'hA5, 8'h03});
        tick();
        check("cont_no_overrun", err_overrun, 1'b0);
        check("cont_last_data", mem[8'hA5], 8'h03);

        // ---------------- overrun ----------------
        wr_base   = wr_count;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 8'h10;
        rx_data   = 10'h111;
        rx_valid  = 1'b1;
        tick();
        check("ovr_host_read_gnt", {host_gnt, ram_we, err_overrun}, 3'b100);
        rx_valid = 1'b0;
        tick();
        rx_data  = 10'h122;
        rx_valid = 1'b1;
        tick();
        check("ovr_flag", err_overrun, 1'b1);
        check("ovr_host_rdata", {host_rvalid, host_rdata}, {1'b1, 8'h55});
        rx_valid = 1'b0;
        tick();
        check("ovr_second_write", {host_gnt, ram_en, ram_we, ram_addr, ram_wdata},
              {1'b0, 1'b1, 1'b1, 8'hA5, 8'h22});
        tick();
        tick();
        check("ovr_host_again", host_gnt, 1'b1);
        host_req = 1'b0;
        repeat (4) tick();
        check("ovr_one_write", wr_count - wr_base, 1);
        check("ovr_mem", mem[8'hA5], 8'h22);
        check("ovr_sticky", err_overrun, 1'b1);

        // ---------------- reset during RD_WAIT ----------------
        spi_rise(10'h300);
        spi_fall();                               // now in RD_WAIT
        rstn = 1'b0;
        tick();
        check("rst_mid_read_outputs", all_outs(), 64'd0);
        rstn = 1'b1;
        tick();
        check("rst_release_quiet", {ram_en, tx_valid, host_rvalid}, 3'b000);
        repeat (2) tick();
        check("rst_no_late_tx", {tx_valid, ram_en}, 2'b00);
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 8'h20;
        host_wdata = 8'h99;
        tick();
        check("rst_fsm_idle", {host_gnt, ram_addr, ram_wdata}, {1'b1, 8'h20, 8'h99});
        host_req = 1'b0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
